encode_pack: RTL and testbench
==============================

ENCODE_PACK -- requirements
Module: encode_pack

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 16, meaning output word width; legal values 16, 32, 64.
REQ-002 SHALL have parameter CODE_WIDTH, default 13, meaning maximum code width per request.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, meaning width of the code-length field.
REQ-004 SHALL have parameter END_MARK, default 1, meaning 1 = append LZS end marker 9'b1_1000_0000 on finish, 0 = none.
REQ-005 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  global enable; 0 freezes all state.
- cnt_output_enable  input  1  code request valid.
- cnt_output  input  CODE_WIDTH  code bits, right-justified.
- cnt_len  input  LEN_WIDTH  number of valid code bits, 0..CODE_WIDTH.
- cnt_finish  input  1  end-of-stream request.
- fo_full  input  1  downstream FIFO full.
- ready_o  output  1  request accepted this cycle when high.
- data_o  output  OUT_WIDTH  packed word.
- valid_o  output  1  data_o write strobe, one cycle per word.
- done_o  output  1  one-cycle end-of-stream pulse.
- words_o  output  16  words emitted since last reset, wraps at 0xFFFF.

Function
REQ-006 SHALL accept a code when ce & cnt_output_enable & ready_o, and SHALL accept a finish when ce & cnt_finish & ready_o.
REQ-007 SHALL pack bits MSB-first: each accepted code occupies the most significant free positions of a (OUT_WIDTH+CODE_WIDTH)-bit accumulator.
REQ-008 SHALL keep a fill counter of ceil(log2(OUT_WIDTH+CODE_WIDTH+1)) bits, incremented by cnt_len on accept and decremented by OUT_WIDTH on emit, both possible in the same cycle.
REQ-009 SHALL drive ready_o = ce & (state==RUN) & (fill < OUT_WIDTH), so an accepted code never overflows the accumulator.
REQ-010 SHALL emit a word (register data_o = top OUT_WIDTH accumulator bits, valid_o=1, shift left by OUT_WIDTH) on an edge where ce=1, fill>=OUT_WIDTH and fo_full=0; otherwise valid_o=0 and data_o holds.
REQ-011 SHALL give latency of 2 cycles: a code accepted in cycle N that completes a word produces valid_o=1 in cycle N+2 when fo_full=0 throughout.
REQ-012 SHALL treat cnt_len=0 as an accepted no-op; cnt_len>CODE_WIDTH is illegal and flagged by a bench assertion.
REQ-013 SHALL implement states IDLE, RUN, MARK, FLUSH, DONE; reset enters IDLE; IDLE->RUN next ce cycle.
REQ-014 SHALL, on finish acceptance in RUN, go to MARK if END_MARK=1, else to FLUSH; a code and finish in the same cycle SHALL pack the code first.
REQ-015 SHALL, in MARK, append 9 marker bits once fill<OUT_WIDTH, then go to FLUSH.
REQ-016 SHALL, in FLUSH, emit full words; if 0<fill<OUT_WIDTH, zero-pad to OUT_WIDTH and emit; when fill=0 go to DONE.
REQ-017 SHALL assert done_o for exactly one cycle in DONE, then return to IDLE; fill=0 at finish with END_MARK=0 emits no word.
REQ-018 SHALL hold all state, outputs and counters when ce=0; valid_o and done_o SHALL be 0 while ce=0.
REQ-019 SHALL increment words_o on every valid_o.

Reset
REQ-020 SHALL on rst=1 set state=IDLE, fill=0, accumulator=0, data_o=0, valid_o=0, done_o=0, words_o=0; ready_o=0 in the reset cycle.
REQ-021 SHALL discard all partial data on reset mid-stream or mid-flush, with no further valid_o or done_o.

Structure
REQ-022 SHALL place the state encoding, the LZS end-marker constant (9'h180) and its length 9 in the shared encode package/header.
REQ-023 SHALL be one module; a sub-module encode_pack_shift (variable left-shift insert into the accumulator) is natural and permitted.

Verification
REQ-024 Reset: rst high 2 cycles -> valid_o=0, done_o=0, data_o=0, words_o=0; ready_o=1 two cycles after rst drops.
REQ-025 Packing (OUT_WIDTH=16): codes 9'h041 len 9, then 7'h55 len 7 -> one word data_o=16'h20D5, words_o=1.
REQ-026 Finish (END_MARK=1): code 4'hA len 4, then cnt_finish -> data_o=16'hAC00, then done_o pulse, state IDLE.
REQ-027 Backpressure: fill>=16 with fo_full=1 for 5 cycles -> valid_o=0, ready_o=0; fo_full=0 -> word emitted, no bits lost versus a reference model.
REQ-028 ce=0 for 4 cycles mid-stream -> outputs frozen, output stream identical to the ce=1 run.
REQ-029 Random codes, OUT_WIDTH=32 and 64, random fo_full/ce, reset mid-flush -> bit stream matches model; no valid_o/done_o after reset.

Source files
------------

// File: rtl/encode_pack_pkg.sv
// Shared constants for the LZS bit packer: FSM encoding and the end-of-stream marker.
package encode_pack_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_MARK  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [8:0] LZS_END_MARK = 9'h180;
  localparam int         LZS_END_LEN  = 9;

endpackage

// File: rtl/encode_pack_shift.sv
// Inserts a right-justified field of ins_len bits into the accumulator,
// MSB-aligned at bit position pos counted from the accumulator's top.
module encode_pack_shift #(
  parameter int ACC_WIDTH  = 29,
  parameter int FILL_WIDTH = 5
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [FILL_WIDTH-1:0] pos,
  input  logic [ACC_WIDTH-1:0]  ins_bits,
  input  logic [FILL_WIDTH-1:0] ins_len,
  input  logic                  ins_en,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  localparam logic [FILL_WIDTH-1:0] ACC_W_F = FILL_WIDTH'(ACC_WIDTH);

  logic [ACC_WIDTH-1:0]  mask;
  logic [ACC_WIDTH-1:0]  field;
  logic [FILL_WIDTH-1:0] sh;

  // Bits above the code length are don't-care on the input, so strip them.
  for (genvar gi = 0; gi < ACC_WIDTH; gi++) begin : g_mask
    assign mask[gi] = (FILL_WIDTH'(gi) < ins_len);
  end

  always_comb begin
    sh      = ACC_W_F - pos - ins_len;
    field   = (ins_bits & mask) << sh;
    acc_out = ins_en ? (acc | field) : acc;
  end

endmodule

// File: rtl/encode_pack.sv
// MSB-first variable-length code packer with optional LZS end marker,
// zero-padded flush and downstream FIFO backpressure.
module encode_pack
  import encode_pack_pkg::*;
#(
  parameter int OUT_WIDTH  = 16,
  parameter int CODE_WIDTH = 13,
  parameter int LEN_WIDTH  = 4,
  parameter int END_MARK   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  cnt_output_enable,
  input  logic [CODE_WIDTH-1:0] cnt_output,
  input  logic [LEN_WIDTH-1:0]  cnt_len,
  input  logic                  cnt_finish,
  input  logic                  fo_full,
  output logic                  ready_o,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  output logic                  done_o,
  output logic [15:0]           words_o
);

  localparam int ACC_WIDTH  = OUT_WIDTH + CODE_WIDTH;
  localparam int FILL_WIDTH = $clog2(ACC_WIDTH + 1);
  localparam logic [FILL_WIDTH-1:0] OUT_W_F = FILL_WIDTH'(OUT_WIDTH);

  logic [2:0]            state_reg, state_next;
  logic [FILL_WIDTH-1:0] fill_reg, fill_next, fill_base;
  logic [ACC_WIDTH-1:0]  acc_reg, acc_next, acc_base;
  logic [OUT_WIDTH-1:0]  data_reg;
  logic                  valid_reg;
  logic [15:0]           words_reg;

  logic [ACC_WIDTH-1:0]  ins_bits;
  logic [FILL_WIDTH-1:0] ins_len;
  logic                  ins_en;
  logic                  accept_code, accept_finish;
  logic                  emit_full, emit_pad, emit, mark_ins;

  // Accepting only below one word of fill guarantees the accumulator never overflows.
  assign ready_o       = ce & ~rst & (state_reg == ST_RUN) & (fill_reg < OUT_W_F);
  assign accept_code   = ready_o & cnt_output_enable;
  assign accept_finish = ready_o & cnt_finish;

  assign emit_full = (fill_reg >= OUT_W_F) & ~fo_full;
  assign emit_pad  = (state_reg == ST_FLUSH) & (fill_reg != '0) & (fill_reg < OUT_W_F) & ~fo_full;
  assign emit      = emit_full | emit_pad;
  assign mark_ins  = (state_reg == ST_MARK) & (fill_reg < OUT_W_F) & (END_MARK != 0);

  always_comb begin
    acc_base  = emit ? (acc_reg << OUT_WIDTH) : acc_reg;
    fill_base = emit_full ? (fill_reg - OUT_W_F) : (emit_pad ? '0 : fill_reg);
    ins_en    = 1'b0;
    ins_bits  = '0;
    ins_len   = '0;
    if (accept_code) begin
      ins_en   = 1'b1;
      ins_bits = ACC_WIDTH'(cnt_output);
      ins_len  = FILL_WIDTH'(cnt_len);
    end else if (mark_ins) begin
      ins_en   = 1'b1;
      ins_bits = ACC_WIDTH'(LZS_END_MARK);
      ins_len  = FILL_WIDTH'(LZS_END_LEN);
    end
    fill_next = fill_base + (ins_en ? ins_len : '0);
  end

  encode_pack_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .FILL_WIDTH(FILL_WIDTH)
  ) u_shift (
    .acc     (acc_base),
    .pos     (fill_base),
    .ins_bits(ins_bits),
    .ins_len (ins_len),
    .ins_en  (ins_en),
    .acc_out (acc_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  state_next = ST_RUN;
      ST_RUN:   if (accept_finish) state_next = (END_MARK != 0) ? ST_MARK : ST_FLUSH;
      ST_MARK:  if (fill_reg < OUT_W_F) state_next = ST_FLUSH;
      ST_FLUSH: if (fill_reg == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      fill_reg  <= '0;
      acc_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      words_reg <= '0;
    end else if (ce) begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      acc_reg   <= acc_next;
      valid_reg <= emit;
      if (emit) begin
        data_reg  <= acc_reg[ACC_WIDTH-1 -: OUT_WIDTH];
        words_reg <= words_reg + 16'd1;
      end
    end
  end

  // Strobes are gated so a frozen or resetting block never presents a write.
  assign data_o  = data_reg;
  assign valid_o = valid_reg & ce & ~rst;
  assign done_o  = ce & ~rst & (state_reg == ST_DONE);
  assign words_o = words_reg;

endmodule

// File: tb/tb_encode_pack.sv
// Scoreboard bench for encode_pack at OUT_WIDTH 16, 32 and 64 with a bit-queue model.
module tb_encode_pack;

  localparam int NDUT = 3;
  localparam int CW   = 13;
  localparam int LW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a  [NDUT];
  logic          ce_a   [NDUT];
  logic          en_a   [NDUT];
  logic          fin_a  [NDUT];
  logic          full_a [NDUT];
  logic [CW-1:0] code_a [NDUT];
  logic [LW-1:0] len_a  [NDUT];
  logic          ready_a[NDUT];
  logic          valid_a[NDUT];
  logic          done_a [NDUT];
  logic [63:0]   data_a [NDUT];
  logic [15:0]   words_a[NDUT];

  int n_vec = 0;
  int n_bad = 0;

  bit          mbits    [NDUT][$];
  logic [63:0] exp_q    [NDUT][$];
  int          done_pend[NDUT];
  int          exp_words[NDUT];
  logic [63:0] last_word[NDUT];

  bit rand_mode = 1'b0;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int OW = 16 << gi;
    logic [OW-1:0] dw;

    encode_pack #(
      .OUT_WIDTH (OW),
      .CODE_WIDTH(CW),
      .LEN_WIDTH (LW),
      .END_MARK  (1)
    ) u_dut (
      .clk              (clk),
      .rst              (rst_a[gi]),
      .ce               (ce_a[gi]),
      .cnt_output_enable(en_a[gi]),
      .cnt_output       (code_a[gi]),
      .cnt_len          (len_a[gi]),
      .cnt_finish       (fin_a[gi]),
      .fo_full          (full_a[gi]),
      .ready_o          (ready_a[gi]),
      .data_o           (dw),
      .valid_o          (valid_a[gi]),
      .done_o           (done_a[gi]),
      .words_o          (words_a[gi])
    );
    assign data_a[gi] = 64'(dw);

    // Scoreboard: every written word is popped and compared against the model.
    always @(negedge clk) begin
      logic [63:0] w;
      if (valid_a[gi]) begin
        n_vec++;
        if (exp_q[gi].size() == 0) begin
          n_bad++;
          $display("FAIL word_unexpected dut%0d: got %h, required no word", gi, data_a[gi]);
        end else begin
          w = exp_q[gi].pop_front();
          last_word[gi] = w;
          if (data_a[gi] !== w) begin
            n_bad++;
            $display("FAIL word_data dut%0d: got %h, required %h", gi, data_a[gi], w);
          end
        end
        exp_words[gi]++;
        n_vec++;
        if (words_a[gi] !== 16'(exp_words[gi])) begin
          n_bad++;
          $display("FAIL words_count dut%0d: got %0d, required %0d", gi, words_a[gi], exp_words[gi]);
        end
      end
      if (done_a[gi]) begin
        n_vec++;
        if (done_pend[gi] == 0) begin
          n_bad++;
          $display("FAIL done_unexpected dut%0d: got done_o=1, required 0", gi);
        end else begin
          done_pend[gi]--;
        end
      end
    end

    always @(posedge clk)
      if (!rst_a[gi] && en_a[gi])
        assert (int'(len_a[gi]) <= CW) else $error("illegal cnt_len %0d on dut%0d", len_a[gi], gi);
  end

  function automatic int ow(input int d);
    return 16 << d;
  endfunction

  task automatic model_bits(input int d, input logic [63:0] v, input int len);
    logic [63:0] w;
    for (int i = len - 1; i >= 0; i--) mbits[d].push_back(v[i]);
    while (mbits[d].size() >= ow(d)) begin
      w = '0;
      for (int k = 0; k < ow(d); k++) w = {w[62:0], mbits[d].pop_front()};
      exp_q[d].push_back(w);
    end
  endtask

  task automatic model_finish(input int d);
    int n;
    model_bits(d, 64'h180, 9);
    n = mbits[d].size();
    if (n > 0) model_bits(d, 64'h0, ow(d) - n);
    done_pend[d]++;
  endtask

  task automatic model_reset(input int d);
    mbits[d].delete();
    exp_q[d].delete();
    done_pend[d] = 0;
    exp_words[d] = 0;
    last_word[d] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jitter(input int d);
    if (rand_mode) begin
      ce_a[d]   = ($urandom_range(0, 99) < 80);
      full_a[d] = ($urandom_range(0, 99) < 30);
    end
  endtask

  task automatic send_code(input int d, input logic [CW-1:0] v, input logic [LW-1:0] len);
    bit ok;
    ok = 1'b0;
    en_a[d] = 1'b1; code_a[d] = v; len_a[d] = len;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (ready_a[d]) begin
        model_bits(d, 64'(v), int'(len));
        ok = 1'b1;
      end
      tick();
      jitter(d);
    end
    en_a[d] = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept_code dut%0d: got ready_o=0 for 400 cycles, required 1", d);
    end
  endtask

  task automatic send_finish(input int d);
    bit ok;
    ok = 1'b0;
    fin_a[d] = 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (ready_a[d]) begin
        model_finish(d);
        ok = 1'b1;
      end
      tick();
      jitter(d);
    end
    fin_a[d] = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept_finish dut%0d: got ready_o=0 for 400 cycles, required 1", d);
    end
  endtask

  // Returns at the negedge where the strobe is seen, or after the budget expires.
  task automatic wait_sig(input int d, input bit want_done, input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (want_done ? done_a[d] : valid_a[d]) seen = 1'b1;
      else begin
        tick();
        jitter(d);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      rst_a[d] = 1'b1; ce_a[d] = 1'b1; en_a[d] = 1'b0; fin_a[d] = 1'b0;
      full_a[d] = 1'b0; code_a[d] = '0; len_a[d] = '0;
      model_reset(d);
    end
    tick();
    tick();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_vec += 5;
      if (valid_a[d] !== 1'b0) begin n_bad++; $display("FAIL reset_valid dut%0d: got %b, required 0", d, valid_a[d]); end
      if (done_a[d] !== 1'b0) begin n_bad++; $display("FAIL reset_done dut%0d: got %b, required 0", d, done_a[d]); end
      if (data_a[d] !== 64'h0) begin n_bad++; $display("FAIL reset_data dut%0d: got %h, required 0", d, data_a[d]); end
      if (words_a[d] !== 16'h0) begin n_bad++; $display("FAIL reset_words dut%0d: got %0d, required 0", d, words_a[d]); end
      if (ready_a[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b, required 0", d, ready_a[d]); end
    end
    tick();
    for (int d = 0; d < NDUT; d++) rst_a[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_vec++;
      if (ready_a[d] !== 1'b0) begin n_bad++; $display("FAIL idle_ready dut%0d: got %b, required 0", d, ready_a[d]); end
    end
    tick();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_vec++;
      if (ready_a[d] !== 1'b1) begin n_bad++; $display("FAIL run_ready dut%0d: got %b, required 1", d, ready_a[d]); end
    end
    tick();
  endtask

  task automatic test_packing();
    send_code(0, 13'h041, 4'd9);
    send_code(0, 13'h055, 4'd7);
    @(negedge clk);
    n_vec++;
    if (valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL latency_early: got valid_o=%b, required 0", valid_a[0]); end
    tick();
    @(negedge clk);
    n_vec += 3;
    if (valid_a[0] !== 1'b1) begin n_bad++; $display("FAIL latency_two: got valid_o=%b, required 1", valid_a[0]); end
    if (data_a[0][15:0] !== 16'h20D5) begin n_bad++; $display("FAIL pack_word: got %h, required 20d5", data_a[0][15:0]); end
    if (words_a[0] !== 16'd1) begin n_bad++; $display("FAIL pack_words: got %0d, required 1", words_a[0]); end
    tick();
  endtask

  task automatic test_finish();
    bit seen;
    send_code(0, 13'h00A, 4'd4);
    send_finish(0);
    wait_sig(0, 1'b0, 20, seen);
    n_vec += 2;
    if (!seen) begin n_bad++; $display("FAIL finish_word_seen: got no valid_o in 20 cycles, required 1"); end
    if (data_a[0][15:0] !== 16'hAC00) begin n_bad++; $display("FAIL finish_word: got %h, required ac00", data_a[0][15:0]); end
    tick();
    wait_sig(0, 1'b1, 20, seen);
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL finish_done: got no done_o in 20 cycles, required 1"); end
    tick();
    @(negedge clk);
    n_vec += 2;
    if (done_a[0] !== 1'b0) begin n_bad++; $display("FAIL done_width: got done_o=%b, required 0", done_a[0]); end
    if (ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL done_to_idle: got ready_o=%b, required 0", ready_a[0]); end
    tick();
    @(negedge clk);
    n_vec++;
    if (ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL idle_to_run: got ready_o=%b, required 1", ready_a[0]); end
    tick();
  endtask

  task automatic test_backpressure();
    bit seen;
    full_a[0] = 1'b1;
    send_code(0, 13'h1ABC, 4'd13);
    send_code(0, 13'h0005, 4'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec += 2;
      if (valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL bp_valid c%0d: got %b, required 0", c, valid_a[0]); end
      if (ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL bp_ready c%0d: got %b, required 0", c, ready_a[0]); end
      tick();
    end
    full_a[0] = 1'b0;
    wait_sig(0, 1'b0, 5, seen);
    n_vec += 2;
    if (!seen) begin n_bad++; $display("FAIL bp_release: got no valid_o in 5 cycles, required 1"); end
    if (data_a[0][15:0] !== 16'hD5E5) begin n_bad++; $display("FAIL bp_word: got %h, required d5e5", data_a[0][15:0]); end
    tick();
  endtask

  task automatic test_ce_freeze();
    bit seen;
    send_code(0, 13'h0F0F, 4'd13);
    send_code(0, 13'h0003, 4'd3);
    ce_a[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec += 5;
      if (valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL ce_valid c%0d: got %b, required 0", c, valid_a[0]); end
      if (done_a[0] !== 1'b0) begin n_bad++; $display("FAIL ce_done c%0d: got %b, required 0", c, done_a[0]); end
      if (ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL ce_ready c%0d: got %b, required 0", c, ready_a[0]); end
      if (words_a[0] !== 16'(exp_words[0])) begin n_bad++; $display("FAIL ce_words c%0d: got %0d, required %0d", c, words_a[0], exp_words[0]); end
      if (data_a[0] !== last_word[0]) begin n_bad++; $display("FAIL ce_data c%0d: got %h, required %h", c, data_a[0], last_word[0]); end
      tick();
    end
    ce_a[0] = 1'b1;
    wait_sig(0, 1'b0, 5, seen);
    n_vec += 2;
    if (!seen) begin n_bad++; $display("FAIL ce_resume: got no valid_o in 5 cycles, required 1"); end
    if (data_a[0][15:0] !== 16'h787B) begin n_bad++; $display("FAIL ce_word: got %h, required 787b", data_a[0][15:0]); end
    tick();
  endtask

  task automatic test_random(input int d, input int ncodes);
    bit seen;
    int len;
    logic [CW-1:0] v;
    rand_mode = 1'b1;
    for (int i = 0; i < ncodes + 4; i++) begin
      len = $urandom_range(0, CW);
      v = CW'($urandom);
      v = v & ~({CW{1'b1}} << len);
      send_code(d, v, LW'(len));
      if (i % 40 == 39) begin
        send_finish(d);
        wait_sig(d, 1'b1, 400, seen);
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL rand_done dut%0d: got no done_o in 400 cycles, required 1", d); end
        tick();
      end
    end
    // Abandon a stream mid-flush: nothing of it may appear afterwards.
    send_finish(d);
    repeat ($urandom_range(0, 2)) tick();
    rst_a[d] = 1'b1;
    model_reset(d);
    tick();
    tick();
    rst_a[d] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_vec++;
      if (valid_a[d] !== 1'b0 || done_a[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset dut%0d c%0d: got valid_o=%b done_o=%b, required 0 0", d, c, valid_a[d], done_a[d]);
      end
      tick();
      jitter(d);
    end
    n_vec++;
    if (words_a[d] !== 16'h0) begin n_bad++; $display("FAIL post_reset_words dut%0d: got %0d, required 0", d, words_a[d]); end
    rand_mode = 1'b0;
    ce_a[d] = 1'b1;
    full_a[d] = 1'b0;
  endtask

  task automatic test_drain();
    bit seen;
    for (int d = 0; d < NDUT; d++) begin
      send_code(d, 13'h1555, 4'd11);
      send_finish(d);
      wait_sig(d, 1'b1, 200, seen);
      n_vec++;
      if (!seen) begin n_bad++; $display("FAIL drain_done dut%0d: got no done_o in 200 cycles, required 1", d); end
      tick();
      n_vec++;
      if (exp_q[d].size() != 0 || done_pend[d] != 0) begin
        n_bad++;
        $display("FAIL drain_empty dut%0d: got %0d words %0d done pending, required 0 0", d, exp_q[d].size(), done_pend[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_finish();
    test_backpressure();
    test_ce_freeze();
    test_random(0, 120);
    test_random(1, 150);
    test_random(2, 150);
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
